// File: rtl/adcsnap_capture_ctrl_if.sv
// Groups the software control words, the ADC sample stream, the BRAM write port and the status readback.
// Latency: none; wires only.
// Backpressure: none; the sample stream is qualified by din_valid only.
interface adcsnap_capture_ctrl_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 64
);
   logic [31:0]       ctrl;
   logic [31:0]       trig_offset;
   logic [DATA_W-1:0] din;
   logic              din_valid;
   logic              trig;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_data;
   logic              bram_we;
   logic [31:0]       status;
   logic              done;

   // Software/ADC side: drives control words and samples, observes the BRAM port and status
   modport master (
      output ctrl, trig_offset, din, din_valid, trig,
      input  bram_addr, bram_data, bram_we, status, done
   );

   // Capture controller side
   modport slave (
      input  ctrl, trig_offset, din, din_valid, trig,
      output bram_addr, bram_data, bram_we, status, done
   );
endinterface

// File: rtl/adcsnap_capture_ctrl.sv
// ADC snapshot sequencer: arm/trigger detection, pre/post-trigger windowing, BRAM write port, status.
// Latency: each written sample appears on the BRAM port 1 cycle after its din_valid cycle.
// Backpressure: none; din_valid=0 cycles write nothing and freeze every counter.
module adcsnap_capture_ctrl #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 64
) (
   input  logic                  user_clk,
   input  logic                  user_rst_n,
   adcsnap_capture_ctrl_if.slave bus
);
   localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] MAX_M    = {ADDR_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARMED,
      S_DELAY,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t            state, state_nxt;
   logic              arm_q;

   // Capture parameters latched at arm time
   logic [31:0]       off_q, off_nxt;
   logic              imm_q, imm_nxt;
   logic [ADDR_W-1:0] m_q, m_nxt;

   // Progress counters
   logic [ADDR_W-1:0] wr_addr, wr_addr_nxt;
   logic [ADDR_W:0]   fill, fill_nxt;
   logic [ADDR_W:0]   cnt, cnt_nxt;
   logic [31:0]       dcnt, dcnt_nxt;

   // Status fields
   logic [ADDR_W-1:0] start_addr, start_addr_nxt;
   logic              pshort, pshort_nxt;

   // Registered BRAM write port
   logic              we_q, we_nxt;
   logic [ADDR_W-1:0] addr_q, addr_nxt;
   logic [DATA_W-1:0] data_q, data_nxt;

   logic              arm_evt;
   logic              trig_hit;
   logic              off_neg;
   logic [31:0]       off_mag;
   logic [ADDR_W-1:0] m_calc;
   logic [ADDR_W:0]   total;
   logic              busy;
   logic              done_w;
   logic              ctrl_unused;

   assign ctrl_unused = ^bus.ctrl[31:2];

   assign arm_evt  = bus.ctrl[0] & ~arm_q;
   assign trig_hit = (bus.trig | imm_q) & bus.din_valid;
   assign off_neg  = off_q[31];

   // Magnitude of a negative offset; the most negative value maps to 2^31, which clamps like any large one
   assign off_mag = bus.trig_offset[31] ? (32'd0 - bus.trig_offset) : 32'd0;
   assign m_calc  = (off_mag > 32'(MAX_M)) ? MAX_M : off_mag[ADDR_W-1:0];

   // Writes from the trigger sample onward: the history window eats into the buffer
   assign total = off_neg ? (DEPTH - {1'b0, m_q}) : DEPTH;

   // Next-state and datapath decisions; everything holds unless a branch says otherwise
   always_comb begin
      state_nxt      = state;
      off_nxt        = off_q;
      imm_nxt        = imm_q;
      m_nxt          = m_q;
      wr_addr_nxt    = wr_addr;
      fill_nxt       = fill;
      cnt_nxt        = cnt;
      dcnt_nxt       = dcnt;
      start_addr_nxt = start_addr;
      pshort_nxt     = pshort;
      we_nxt         = 1'b0;
      addr_nxt       = addr_q;
      data_nxt       = data_q;

      case (state)
         S_IDLE, S_DONE: begin
            if (arm_evt) begin
               off_nxt        = bus.trig_offset;
               imm_nxt        = bus.ctrl[1];
               m_nxt          = m_calc;
               wr_addr_nxt    = '0;
               fill_nxt       = '0;
               cnt_nxt        = '0;
               dcnt_nxt       = '0;
               start_addr_nxt = '0;
               pshort_nxt     = 1'b0;
               state_nxt      = S_ARMED;
            end
         end

         S_ARMED: begin
            if (off_neg) begin
               // History mode: every valid sample goes into the ring, trigger included
               if (bus.din_valid) begin
                  we_nxt      = 1'b1;
                  addr_nxt    = wr_addr;
                  data_nxt    = bus.din;
                  wr_addr_nxt = wr_addr + ADDR_ONE;
                  if (trig_hit) begin
                     start_addr_nxt = wr_addr - m_q;
                     pshort_nxt     = (fill < {1'b0, m_q});
                     cnt_nxt        = CNT_ONE;
                     state_nxt      = (total == CNT_ONE) ? S_DONE : S_CAPTURE;
                  end else if (fill != DEPTH) begin
                     fill_nxt = fill + CNT_ONE;
                  end
               end
            end else if (trig_hit) begin
               if (off_q == 32'd0) begin
                  we_nxt      = 1'b1;
                  addr_nxt    = '0;
                  data_nxt    = bus.din;
                  wr_addr_nxt = ADDR_ONE;
                  cnt_nxt     = CNT_ONE;
                  state_nxt   = S_CAPTURE;
               end else begin
                  dcnt_nxt  = 32'd1;
                  state_nxt = S_DELAY;
               end
            end
         end

         S_DELAY: begin
            // dcnt is the index of the current valid sample relative to the trigger sample
            if (bus.din_valid) begin
               if (dcnt == off_q) begin
                  we_nxt      = 1'b1;
                  addr_nxt    = '0;
                  data_nxt    = bus.din;
                  wr_addr_nxt = ADDR_ONE;
                  cnt_nxt     = CNT_ONE;
                  state_nxt   = S_CAPTURE;
               end else begin
                  dcnt_nxt = dcnt + 32'd1;
               end
            end
         end

         S_CAPTURE: begin
            if (bus.din_valid) begin
               we_nxt      = 1'b1;
               addr_nxt    = wr_addr;
               data_nxt    = bus.din;
               wr_addr_nxt = wr_addr + ADDR_ONE;
               cnt_nxt     = cnt + CNT_ONE;
               if ((cnt + CNT_ONE) == total) begin
                  state_nxt = S_DONE;
               end
            end
         end

         default: state_nxt = S_IDLE;
      endcase
   end

   // State register and arm edge detector
   always_ff @(posedge user_clk) begin
      if (!user_rst_n) begin
         state <= S_IDLE;
         arm_q <= 1'b0;
      end else begin
         state <= state_nxt;
         arm_q <= bus.ctrl[0];
      end
   end

   // Latched parameters, counters, status fields and the registered BRAM port
   always_ff @(posedge user_clk) begin
      if (!user_rst_n) begin
         off_q      <= '0;
         imm_q      <= 1'b0;
         m_q        <= '0;
         wr_addr    <= '0;
         fill       <= '0;
         cnt        <= '0;
         dcnt       <= '0;
         start_addr <= '0;
         pshort     <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
      end else begin
         off_q      <= off_nxt;
         imm_q      <= imm_nxt;
         m_q        <= m_nxt;
         wr_addr    <= wr_addr_nxt;
         fill       <= fill_nxt;
         cnt        <= cnt_nxt;
         dcnt       <= dcnt_nxt;
         start_addr <= start_addr_nxt;
         pshort     <= pshort_nxt;
         we_q       <= we_nxt;
         addr_q     <= addr_nxt;
         data_q     <= data_nxt;
      end
   end

   assign busy   = (state == S_ARMED) || (state == S_DELAY) || (state == S_CAPTURE);
   assign done_w = (state == S_DONE);

   assign bus.bram_we   = we_q;
   assign bus.bram_addr = addr_q;
   assign bus.bram_data = data_q;
   assign bus.done      = done_w;
   assign bus.status    = {done_w, busy, pshort, {(29-ADDR_W){1'b0}}, start_addr};
endmodule

// File: tb/tb_adcsnap_capture_ctrl.sv
// Randomized scoreboard bench for the snapshot capture controller.
// Expected BRAM writes are derived from the windowing rules and queued before each capture.
// A monitor pops one entry per observed write; status is checked once each capture settles.
module tb_adcsnap_capture_ctrl;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 64;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              done;
   } wr_t;

   logic user_clk   = 1'b0;
   logic user_rst_n = 1'b0;
   logic vld_prev   = 1'b0;

   int  n_cmp = 0;
   int  n_bad = 0;
   wr_t sb_q[$];
   wr_t mon_e;

   adcsnap_capture_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   adcsnap_capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .user_clk   (user_clk),
      .user_rst_n (user_rst_n),
      .bus        (bus)
   );

   always #5 user_clk = ~user_clk;

   // din_valid as seen by the edge that registers a write
   always @(posedge user_clk) vld_prev <= bus.din_valid;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Monitor: every BRAM write must match the head of the scoreboard
   initial begin
      forever begin
         @(negedge user_clk);
         if (bus.bram_we === 1'b1) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_write: got addr=%0d data=0x%0h, expected no write",
                        bus.bram_addr, bus.bram_data);
            end else begin
               mon_e = sb_q.pop_front();
               if (bus.bram_addr !== mon_e.addr || bus.bram_data !== mon_e.data ||
                   bus.done !== mon_e.done || vld_prev !== 1'b1) begin
                  n_bad++;
                  $display("FAIL write: got addr=%0d data=0x%0h done=%0b src_valid=%0b, expected addr=%0d data=0x%0h done=%0b src_valid=1",
                           bus.bram_addr, bus.bram_data, bus.done, vld_prev,
                           mon_e.addr, mon_e.data, mon_e.done);
               end
            end
         end
      end
   end

   task automatic push_exp(input longint a, input longint d, input bit dn);
      wr_t w;
      w.addr = ADDR_W'(a % DEPTH);
      w.data = DATA_W'(d);
      w.done = dn;
      sb_q.push_back(w);
   endtask

   // Reference: valid sample i (counted from the first ARMED cycle) carries base+i; k is the trigger index
   task automatic model(input int off, input int k, input longint base, input int keep,
                        output logic [31:0] exp_status, output int last_idx);
      longint m, tot, start, fill;
      if (off >= 0) begin
         for (int j = 0; j < DEPTH; j++)
            push_exp(j, base + k + off + j, j == DEPTH - 1);
         exp_status = 32'h8000_0000;
         last_idx   = k + off + DEPTH - 1;
      end else begin
         m = -longint'(off);
         if (m > DEPTH - 1) m = DEPTH - 1;
         tot = DEPTH - m;
         for (int i = 0; i < k; i++)
            push_exp(i, base + i, 1'b0);
         for (longint j = 0; j < tot; j++)
            push_exp(k + j, base + k + j, j == tot - 1);
         start = ((longint'(k) - m) % DEPTH + DEPTH) % DEPTH;
         fill  = (k < DEPTH) ? k : DEPTH;
         exp_status = 32'h8000_0000 | ((fill < m) ? 32'h2000_0000 : 32'h0) | 32'(start);
         last_idx   = k + int'(tot) - 1;
      end
      while (keep >= 0 && sb_q.size() > keep) void'(sb_q.pop_back());
   endtask

   // vmode: 0 always valid, 1 alternate, 2 random ~75%. pulse_at: valid index for a mid-capture arm pulse.
   // abort_at: for OFF=0 only, reset right after the write to that address.
   task automatic run(input int off, input bit imm, input int k, input int vmode, input bit arm_hold,
                      input int pulse_at, input int abort_at, input longint base);
      logic [31:0] exp_status;
      int  last, idx, keep, guard;
      bit  v, tog, pulsed, pulse_now;
      keep = (abort_at >= 0) ? abort_at + 1 : -1;
      model(off, k, base, keep, exp_status, last);

      // Arm cycle: a valid sample with trig high here must not count
      @(posedge user_clk); #1;
      bus.trig_offset = off;
      bus.ctrl        = {30'd0, imm, 1'b1};
      bus.din_valid   = 1'b1;
      bus.din         = 64'hBAD0_BAD0_BAD0_BAD0;
      bus.trig        = 1'b1;

      idx = 0; tog = 1'b1; pulsed = 1'b0;
      while (idx <= last + 5) begin
         @(posedge user_clk); #1;
         bus.trig_offset = $urandom;
         pulse_now = (pulse_at >= 0) && (idx == pulse_at) && !pulsed;
         if (pulse_now) pulsed = 1'b1;
         bus.ctrl = {30'd0, imm, arm_hold | pulse_now};
         case (vmode)
            0:       v = 1'b1;
            1:       begin v = tog; tog = !tog; end
            default: v = ($urandom_range(0, 3) != 0);
         endcase
         bus.din_valid = v;
         if (v) begin
            bus.din = DATA_W'(base + idx);
            if (imm || idx > k) bus.trig = 1'($urandom_range(0, 1));
            else                bus.trig = (idx == k);
            idx++;
         end else begin
            bus.din  = {$urandom, $urandom};
            bus.trig = 1'($urandom_range(0, 1));
         end
         if (abort_at >= 0 && v && (idx - 1) == k + abort_at) break;
      end

      @(posedge user_clk); #1;
      bus.din_valid = 1'b0;
      bus.trig      = 1'b0;
      bus.ctrl      = 32'd0;
      if (abort_at >= 0) begin
         user_rst_n = 1'b0;
         @(posedge user_clk);
         @(negedge user_clk);
         check("abort_bram_we", 64'(bus.bram_we), 64'd0);
         check("abort_status", 64'(bus.status), 64'd0);
         check("abort_pending_writes", 64'(sb_q.size()), 64'd0);
         @(posedge user_clk); #1;
         user_rst_n = 1'b1;
      end else begin
         guard = 0;
         while (sb_q.size() != 0 && guard < 50) begin
            @(posedge user_clk);
            guard++;
         end
         @(negedge user_clk);
         check("missing_writes", 64'(sb_q.size()), 64'd0);
         check("status", 64'(bus.status), 64'(exp_status));
         check("done", 64'(bus.done), 64'd1);
      end
      sb_q.delete();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.ctrl        = 32'd0;
      bus.trig_offset = 32'd0;
      bus.din         = '0;
      bus.din_valid   = 1'b0;
      bus.trig        = 1'b0;
      user_rst_n      = 1'b0;
      repeat (3) @(posedge user_clk);
      @(negedge user_clk);
      check("reset_bram_we", 64'(bus.bram_we), 64'd0);
      check("reset_bram_addr", 64'(bus.bram_addr), 64'd0);
      check("reset_bram_data", 64'(bus.bram_data), 64'd0);
      check("reset_status", 64'(bus.status), 64'd0);
      check("reset_done", 64'(bus.done), 64'd0);
      @(posedge user_clk); #1;
      user_rst_n = 1'b1;
      repeat (2) @(posedge user_clk);

      // Directed windows
      run(0,     1'b1, 0,   0, 1'b0, -1, -1, 0);
      run(5,     1'b0, 100, 0, 1'b0, -1, -1, 0);
      run(-16,   1'b0, 50,  0, 1'b0, -1, -1, 0);
      run(-2000, 1'b0, 10,  0, 1'b0, -1, -1, 0);
      run(3,     1'b0, 7,   1, 1'b0, -1, -1, longint'($urandom));
      run(int'(32'h8000_0000), 1'b0, 20, 2, 1'b0, 5, -1, longint'($urandom));
      // Reset mid-capture after address 300, with an ignored arm pulse earlier in CAPTURE
      run(0,     1'b0, 3,   0, 1'b0, 200, 300, longint'($urandom));
      // Randomized windows
      run(-int'($urandom_range(1, 600)), 1'b0, int'($urandom_range(0, 1500)), 2, 1'b0, -1, -1,
          longint'($urandom));
      run(int'($urandom_range(1, 50)), 1'b0, 0, 2, 1'b0, -1, -1, longint'($urandom));
      run(-100,  1'b1, 0,   2, 1'b1, -1, -1, longint'($urandom));
      run(-int'($urandom_range(1, 1023)), 1'b0, int'($urandom_range(0, 300)), 2, 1'b0, -1, -1,
          longint'($urandom));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
